// File: rtl/ram_loader_if.sv
// Byte-stream receive channel and RAM load port shared by ram_loader and its neighbours.
interface ram_loader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_we;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, ld_addr, ld_data, ld_we
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, ld_addr, ld_data, ld_we
  );
endinterface

// File: rtl/ram_loader.sv
// Framed 16-byte program loader: hunts for the sync byte, writes the image into RAM,
// checks an additive checksum and holds/resets the CPU around the load.
module ram_loader #(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] HEADER = DATA_W'(8'hA5)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        abort,
  ram_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_WR, S_CSUM, S_RST, S_DONE, S_ERR
  } state_e;

  state_e            state;
  state_e            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] sum;
  logic              accept_c;

  assign accept_c = bus.rx_valid & bus.rx_ready;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; abort only matters while a frame is being received
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_ERR: if (start) state_next = S_SYNC;
      S_SYNC: begin
        if (abort)                                    state_next = S_IDLE;
        else if (accept_c && bus.rx_data == HEADER)   state_next = S_DATA;
      end
      S_DATA: begin
        if (abort)         state_next = S_IDLE;
        else if (accept_c) state_next = S_WR;
      end
      S_WR: begin
        if (abort)                state_next = S_IDLE;
        else if (cnt == CNT_LAST) state_next = S_CSUM;
        else                      state_next = S_DATA;
      end
      S_CSUM: begin
        if (abort)         state_next = S_IDLE;
        else if (accept_c) state_next = (bus.rx_data == sum) ? S_RST : S_ERR;
      end
      S_RST:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only; ERR keeps the CPU held
  always_comb begin
    bus.rx_ready = 1'b0;
    bus.ld_we    = 1'b0;
    cpu_hold     = 1'b0;
    cpu_rst      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_SYNC, S_DATA, S_CSUM: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        cpu_hold     = 1'b1;
      end
      S_WR: begin
        bus.ld_we = 1'b1;
        busy      = 1'b1;
        cpu_hold  = 1'b1;
      end
      S_RST: begin
        cpu_rst  = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE:  done     = 1'b1;
      S_ERR:   cpu_hold = 1'b1;
      default: ;
    endcase
  end

  // Datapath: byte counter, running checksum, load port and sticky error
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt         <= '0;
      sum         <= '0;
      bus.ld_addr <= '0;
      bus.ld_data <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR: if (start) err <= 1'b0;
        S_SYNC: begin
          if (abort) err <= 1'b1;
          else if (accept_c && bus.rx_data == HEADER) begin
            cnt <= '0;
            sum <= '0;
          end
        end
        S_DATA: begin
          if (abort) err <= 1'b1;
          else if (accept_c) begin
            bus.ld_addr <= cnt;
            bus.ld_data <= bus.rx_data;
            sum         <= sum + bus.rx_data;
          end
        end
        S_WR: begin
          cnt <= cnt + ADDR_W'(1);
          if (abort) err <= 1'b1;
        end
        S_CSUM: begin
          if (abort) err <= 1'b1;
          else if (accept_c && bus.rx_data != sum) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: a frame-level model predicts writes and completion,
// a negedge monitor checks every load-port write, cpu_rst and done pulse against it.
`timescale 1ns/1ps
module tb_ram_loader;

  logic clk   = 1'b0;
  logic clr   = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cpu_hold, cpu_rst, busy, done, err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int e0 = 0;
  int done_seen = 0;
  int rst_seen = 0;
  int mon_t;

  logic [11:0] exp_wr_q[$];
  int          exp_rst_q[$];
  int          exp_done_q[$];
  logic [7:0]  stim_q[$];
  logic [7:0]  dat[16];

  ram_loader_if bus ();

  ram_loader dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference model: hunt for A5, next 16 bytes land at addresses 0..15, then the
  // checksum byte must equal their sum mod 256. Returns 0 incomplete, 1 good, 2 bad.
  function automatic int model(output int hdr_idx);
    int         k = 0;
    logic [7:0] s = 8'h00;
    bit         hunting = 1'b1;
    hdr_idx = -1;
    foreach (stim_q[i]) begin
      if (hunting) begin
        if (stim_q[i] == 8'hA5) begin
          hunting = 1'b0;
          hdr_idx = i;
        end
      end else if (k < 16) begin
        exp_wr_q.push_back({4'(k), stim_q[i]});
        s = s + stim_q[i];
        k++;
      end else begin
        return (stim_q[i] == s) ? 1 : 2;
      end
    end
    return 0;
  endfunction

  function automatic logic [7:0] sum_dat();
    int s = 0;
    foreach (dat[i]) s += int'(dat[i]);
    return 8'(s % 256);
  endfunction

  task automatic push_frame(input logic [7:0] csum);
    stim_q.push_back(8'hA5);
    foreach (dat[i]) stim_q.push_back(dat[i]);
    stim_q.push_back(csum);
  endtask

  // Monitor: every strobe or pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (clr) begin
      if (bus.ld_we) begin
        if (exp_wr_q.size() == 0) chk("spurious_we", 32'(bus.ld_we), 32'(0));
        else chk("write_addr_data", 32'({bus.ld_addr, bus.ld_data}), 32'(exp_wr_q.pop_front()));
      end
      if (cpu_rst) begin
        rst_seen++;
        if (exp_rst_q.size() == 0) chk("spurious_cpu_rst", 32'(cpu_rst), 32'(0));
        else begin
          mon_t = exp_rst_q.pop_front();
          chk("cpu_rst_hold", 32'(cpu_hold), 32'(1));
          if (mon_t >= 0) chk("cpu_rst_cycle", cyc, mon_t);
        end
      end
      if (done) begin
        done_seen++;
        if (exp_done_q.size() == 0) chk("spurious_done", 32'(done), 32'(0));
        else begin
          mon_t = exp_done_q.pop_front();
          chk("done_flags", 32'({cpu_hold, busy, err}), 32'(0));
          if (mon_t >= 0) chk("done_cycle", cyc, mon_t);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge
  task automatic do_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_flags", 32'({busy, cpu_hold, err, bus.rx_ready}), 32'(4'b1101));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic r = 1'b0;
    bit   ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int n = 0; n < 100; n++) begin
      r = bus.rx_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_wait", 32'(r), 32'(1));
    @(negedge clk);
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("ready_in_gap", 32'(bus.rx_ready), 32'(1));
      end
    end
  endtask

  task automatic run_session(input int gap_lo, input int gap_hi, input bit timed,
                             input bit with_abort);
    int hdr;
    int outc;
    int d0;
    int r0;
    int gap;
    outc = model(hdr);
    d0 = done_seen;
    r0 = rst_seen;
    do_start(with_abort);
    if (outc == 1) begin
      exp_rst_q.push_back(timed ? e0 + 34 + hdr : -1);
      exp_done_q.push_back(timed ? e0 + 35 + hdr : -1);
    end
    foreach (stim_q[i]) begin
      gap = (i == stim_q.size() - 1) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      send_byte(stim_q[i], gap);
    end
    bus.rx_valid = 1'b0;
    if (outc == 1) begin
      for (int w = 0; w < 400; w++) begin
        if (done_seen != d0) break;
        @(negedge clk);
      end
      chk("done_seen", done_seen, d0 + 1);
      @(negedge clk);
      chk("good_idle_flags", 32'({cpu_hold, busy, err}), 32'(0));
    end else begin
      repeat (3) @(negedge clk);
      chk("bad_flags", 32'({err, cpu_hold, busy}), 32'(3'b110));
      chk("bad_no_done", done_seen, d0);
      chk("bad_no_rst", rst_seen, r0);
    end
    chk("writes_drained", exp_wr_q.size(), 0);
    stim_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr;
    int outc;
    int d0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_values", 32'({bus.rx_ready, bus.ld_addr, bus.ld_data, bus.ld_we,
                             cpu_hold, cpu_rst, busy, done, err}), 32'(0));
    clr = 1'b1;
    @(negedge clk);

    // Good load 00..0F, checksum 78, back-to-back
    for (int i = 0; i < 16; i++) dat[i] = 8'(i);
    push_frame(8'h78);
    run_session(0, 0, 1'b1, 1'b0);

    // Bad checksum, then a fresh good load clears err
    push_frame(8'h79);
    run_session(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
    push_frame(sum_dat());
    run_session(0, 0, 1'b1, 1'b0);

    // Sync hunt
    stim_q.push_back(8'h00);
    stim_q.push_back(8'hFF);
    stim_q.push_back(8'h5A);
    for (int i = 0; i < 16; i++) dat[i] = 8'h11;
    push_frame(8'h10);
    run_session(0, 0, 1'b1, 1'b0);

    // Stalled stream: five idle cycles after every byte
    for (int i = 0; i < 16; i++) dat[i] = 8'(i);
    push_frame(8'h78);
    run_session(5, 5, 1'b0, 1'b0);

    // Reset mid-load after byte 7 has been written
    stim_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) stim_q.push_back(dat[i]);
    outc = model(hdr);
    do_start(1'b0);
    foreach (stim_q[i]) send_byte(stim_q[i], 0);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("midload_reset", 32'({bus.rx_ready, bus.ld_addr, bus.ld_data, bus.ld_we,
                              cpu_hold, cpu_rst, busy, done, err}), 32'(0));
    chk("midload_writes", exp_wr_q.size(), 0);
    stim_q.delete();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    push_frame(8'h78);
    run_session(0, 0, 1'b1, 1'b0);

    // Busy start pulses ignored, abort while byte 9 is offered
    d0 = done_seen;
    stim_q.push_back(8'hA5);
    for (int i = 0; i < 9; i++) stim_q.push_back(8'($urandom));
    outc = model(hdr);
    do_start(1'b0);
    foreach (stim_q[i]) begin
      start = (i == 4 || i == 5);
      send_byte(stim_q[i], 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("abort_pre_ready", 32'(bus.rx_ready), 32'(1));
    bus.rx_data  = 8'($urandom);
    abort        = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    bus.rx_valid = 1'b0;
    chk("abort_flags", 32'({err, cpu_hold, busy, bus.rx_ready}), 32'(4'b1000));
    repeat (4) @(negedge clk);
    chk("abort_writes", exp_wr_q.size(), 0);
    chk("abort_no_done", done_seen, d0);
    stim_q.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_ignored", 32'({err, cpu_hold, busy}), 32'(3'b100));

    // Randomized frames: junk before sync, random gaps, occasional bad checksum
    for (int it = 0; it < 6; it++) begin
      int njunk;
      logic [7:0] j;
      njunk = int'($urandom_range(2, 0));
      for (int k = 0; k < njunk; k++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        stim_q.push_back(j);
      end
      for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
      if ($urandom_range(3, 0) == 0) push_frame(sum_dat() ^ 8'(1 << $urandom_range(7, 0)));
      else push_frame(sum_dat());
      run_session(0, 3, 1'b0, it == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
